dsp_frame_rx: RTL and testbench
===============================

// Module: dsp_frame_rx
// PURPOSE
//  Receive end of the DSP data-push burst stream. A burst is four consecutive dp_vld words: ch1, ch2, ch3, marker.
//  Checks each burst, attaches the UTC/ns timestamp, buffers up to DEPTH frames and drains them as 5-word
//  32-bit frames to the upload path over a valid/ready handshake. Counts gap, marker and overflow errors.
// PARAMETERS
//  DEPTH   4         frame buffer entries; power of 2, >=2
//  MARKER  24'h4444  required 4th word of every burst
//  CNT_W   16        width of the saturating error counters
// PORTS
//  clk_sys       in   1      system clock; single clock domain
//  rst           in   1      synchronous reset, active-high
//  dp_data       in   24     burst word
//  dp_vld        in   1      burst word valid; the 4 words are contiguous
//  dp_utc        in   32     timestamp seconds; stable during the burst
//  dp_ns         in   32     timestamp ns; stable during the burst
//  fr_data       out  32     output frame word
//  fr_vld        out  1      fr_data valid
//  fr_rdy        in   1      downstream accepts fr_data when fr_vld & fr_rdy
//  fr_sof        out  1      marks word 0 of a frame (qualified by fr_vld)
//  fr_eof        out  1      marks word 4 of a frame (qualified by fr_vld)
//  fr_level      out  log2(DEPTH)+1  number of complete frames buffered
//  err_gap_cnt   out  CNT_W  bursts aborted because dp_vld dropped mid-burst
//  err_mark_cnt  out  CNT_W  bursts whose 4th word != MARKER
//  ovf_cnt       out  CNT_W  good bursts dropped because the buffer was full
// BEHAVIOUR
//  Reset: all FSMs idle; pointers, fr_level and all counters = 0; fr_vld/fr_sof/fr_eof = 0; fr_data = 0; partial burst discarded.
//  Capture FSM (C_IDLE, C_W2, C_W3, C_W4), one transition per clk_sys:
//   C_IDLE: dp_vld -> hold ch1 = dp_data, utc = dp_utc, ns = dp_ns; go to C_W2.
//   C_W2 / C_W3: dp_vld -> hold ch2 / ch3; advance. If !dp_vld: err_gap_cnt++, go to C_IDLE.
//   C_W4: dp_vld & dp_data==MARKER -> commit frame if fr_level<DEPTH, else ovf_cnt++.
//         dp_vld & dp_data!=MARKER -> err_mark_cnt++. !dp_vld -> err_gap_cnt++. Always go to C_IDLE.
//   A new burst may start on the cycle right after C_W4. A gap-aborting cycle is not reused as the start of a new burst.
//  Commit: write entry {utc, ns, ch1, ch2, ch3} at wr_ptr, wr_ptr++ (wraps mod DEPTH).
//   The entry is visible to the drain side the next cycle: marker word sampled at edge T gives fr_vld=1 at T+1 at the earliest.
//  Drain FSM: word index 0..4 over the head entry, at rd_ptr.
//   fr_vld = (fr_level != 0).
//   fr_data: w0 = utc; w1 = ns; w2 = {8'h01, ch1}; w3 = {8'h02, ch2}; w4 = {8'h03, ch3}.
//   fr_sof = (idx==0); fr_eof = (idx==4).
//   fr_data and fr_vld are muxed from registered state. While fr_vld & !fr_rdy they hold stable.
//   On fr_vld & fr_rdy, idx++. On w4 accept: idx = 0, rd_ptr++ (wraps).
//  fr_level: +1 on commit, -1 on w4 accept. Both in one cycle: unchanged. A commit in the same cycle as w4 accept
//   with fr_level==DEPTH is an overflow (fullness is sampled before the accept).
//  Error counters saturate at all-ones and never wrap. Each event increments at most once per cycle.
//  rst asserted mid-burst or mid-drain: takes effect on the next edge; no partial frame is ever emitted.
// TESTING
//  1) Burst 0x000111, 0x000222, 0x000333, 0x4444; utc=5, ns=100; fr_rdy=1.
//     -> fr_vld at T+1; words 5, 100, 0x01000111, 0x02000222, 0x03000333; sof on w0, eof on w4.
//  2) Burst with 4th word 0x4445 -> err_mark_cnt=1, fr_vld stays 0.
//     Burst with dp_vld low after word 2 -> err_gap_cnt=1, no frame.
//  3) fr_rdy=0; send 5 good bursts with DEPTH=4 -> fr_level=4, ovf_cnt=1.
//     Then fr_rdy=1 -> exactly 4 frames out, in order.
//  4) fr_level=4; marker committed in the same cycle as a w4 accept -> ovf_cnt++, fr_level=3.
//     With fr_level=3 in the same case -> no ovf, fr_level stays 3.
//  5) Toggle fr_rdy randomly for 100 bursts -> data/order match a model; drops only when full; pointers wrap correctly.
//  6) Assert rst in C_W3 and again during drain at idx=2 -> all outputs 0 next cycle.
//     The next good burst is delivered intact.

Source files
------------

// File: rtl/dsp_frame_rx.sv
// DSP burst receiver: validates 4-word bursts, timestamps them, buffers
// complete frames and drains each one as five 32-bit words.
module dsp_frame_rx #(
    parameter int          DEPTH  = 4,
    parameter logic [23:0] MARKER = 24'h4444,
    parameter int          CNT_W  = 16
) (
    input  logic                     clk_sys,
    input  logic                     rst,
    input  logic [23:0]              dp_data,
    input  logic                     dp_vld,
    input  logic [31:0]              dp_utc,
    input  logic [31:0]              dp_ns,
    output logic [31:0]              fr_data,
    output logic                     fr_vld,
    input  logic                     fr_rdy,
    output logic                     fr_sof,
    output logic                     fr_eof,
    output logic [$clog2(DEPTH):0]   fr_level,
    output logic [CNT_W-1:0]         err_gap_cnt,
    output logic [CNT_W-1:0]         err_mark_cnt,
    output logic [CNT_W-1:0]         ovf_cnt
);

    localparam int LW = $clog2(DEPTH);
    localparam logic [LW:0] FULL = (LW+1)'(DEPTH);

    typedef enum logic [1:0] {C_IDLE, C_W2, C_W3, C_W4} cap_t;

    cap_t state_q, state_d;

    logic [23:0] ch1_q, ch2_q, ch3_q;
    logic [31:0] utc_q, ns_q;

    logic [31:0] mem_utc [DEPTH];
    logic [31:0] mem_ns  [DEPTH];
    logic [23:0] mem_ch1 [DEPTH];
    logic [23:0] mem_ch2 [DEPTH];
    logic [23:0] mem_ch3 [DEPTH];

    logic [LW-1:0] wr_ptr, rd_ptr;
    logic [2:0]    idx_q, idx_d;

    logic gap_ev, mark_ev, good, commit, ovf_ev;
    logic accept, last;
    logic [31:0] word;

    always_ff @(posedge clk_sys) begin
        if (rst) state_q <= C_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        gap_ev  = 1'b0;
        mark_ev = 1'b0;
        good    = 1'b0;
        unique case (state_q)
            C_IDLE: if (dp_vld) state_d = C_W2;
            C_W2: begin
                if (dp_vld) state_d = C_W3;
                else begin
                    gap_ev  = 1'b1;
                    state_d = C_IDLE;
                end
            end
            C_W3: begin
                if (dp_vld) state_d = C_W4;
                else begin
                    gap_ev  = 1'b1;
                    state_d = C_IDLE;
                end
            end
            C_W4: begin
                state_d = C_IDLE;
                if (!dp_vld)               gap_ev  = 1'b1;
                else if (dp_data == MARKER) good    = 1'b1;
                else                        mark_ev = 1'b1;
            end
            default: state_d = C_IDLE;
        endcase
    end

    // Fullness is judged before any same-cycle drain of the head frame.
    assign commit = good & (fr_level != FULL);
    assign ovf_ev = good & (fr_level == FULL);

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            ch1_q <= '0;
            ch2_q <= '0;
            ch3_q <= '0;
            utc_q <= '0;
            ns_q  <= '0;
        end else begin
            if (state_q == C_IDLE && dp_vld) begin
                ch1_q <= dp_data;
                utc_q <= dp_utc;
                ns_q  <= dp_ns;
            end
            if (state_q == C_W2 && dp_vld) ch2_q <= dp_data;
            if (state_q == C_W3 && dp_vld) ch3_q <= dp_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (commit) begin
            mem_utc[wr_ptr] <= utc_q;
            mem_ns[wr_ptr]  <= ns_q;
            mem_ch1[wr_ptr] <= ch1_q;
            mem_ch2[wr_ptr] <= ch2_q;
            mem_ch3[wr_ptr] <= ch3_q;
        end
    end

    assign fr_vld = (fr_level != '0);
    assign accept = fr_vld & fr_rdy;
    assign last   = accept & (idx_q == 3'd4);

    always_comb begin
        idx_d = idx_q;
        if (last)        idx_d = 3'd0;
        else if (accept) idx_d = idx_q + 3'd1;
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            idx_q    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fr_level <= '0;
        end else begin
            idx_q <= idx_d;
            if (commit) wr_ptr <= wr_ptr + LW'(1);
            if (last)   rd_ptr <= rd_ptr + LW'(1);
            if (commit && !last)      fr_level <= fr_level + (LW+1)'(1);
            else if (!commit && last) fr_level <= fr_level - (LW+1)'(1);
        end
    end

    always_comb begin
        word = '0;
        unique case (idx_q)
            3'd0:    word = mem_utc[rd_ptr];
            3'd1:    word = mem_ns[rd_ptr];
            3'd2:    word = {8'h01, mem_ch1[rd_ptr]};
            3'd3:    word = {8'h02, mem_ch2[rd_ptr]};
            3'd4:    word = {8'h03, mem_ch3[rd_ptr]};
            default: word = '0;
        endcase
    end

    assign fr_data = fr_vld ? word : '0;
    assign fr_sof  = fr_vld & (idx_q == 3'd0);
    assign fr_eof  = fr_vld & (idx_q == 3'd4);

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            err_gap_cnt  <= '0;
            err_mark_cnt <= '0;
            ovf_cnt      <= '0;
        end else begin
            if (gap_ev && err_gap_cnt != '1)
                err_gap_cnt <= err_gap_cnt + CNT_W'(1);
            if (mark_ev && err_mark_cnt != '1)
                err_mark_cnt <= err_mark_cnt + CNT_W'(1);
            if (ovf_ev && ovf_cnt != '1)
                ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dsp_frame_rx.sv
// Bench for dsp_frame_rx: frame-queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dsp_frame_rx;

    localparam int          DEPTH  = 4;
    localparam logic [23:0] MARKER = 24'h4444;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [23:0] dp_data;
    logic        dp_vld;
    logic [31:0] dp_utc, dp_ns;
    logic [31:0] fr_data;
    logic        fr_vld, fr_rdy, fr_sof, fr_eof;
    logic [2:0]  fr_level;
    logic [15:0] err_gap_cnt, err_mark_cnt, ovf_cnt;

    int checks = 0;
    int errors = 0;
    bit started = 0;
    bit rdy_mode = 0;

    dsp_frame_rx #(.DEPTH(DEPTH), .MARKER(MARKER), .CNT_W(16)) dut (
        .clk_sys(clk_sys), .rst(rst),
        .dp_data(dp_data), .dp_vld(dp_vld),
        .dp_utc(dp_utc), .dp_ns(dp_ns),
        .fr_data(fr_data), .fr_vld(fr_vld), .fr_rdy(fr_rdy),
        .fr_sof(fr_sof), .fr_eof(fr_eof), .fr_level(fr_level),
        .err_gap_cnt(err_gap_cnt), .err_mark_cnt(err_mark_cnt),
        .ovf_cnt(ovf_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: queue of finished frames, head word index, event counters.
    logic [159:0] mq[$];
    int           midx = 0;
    int           bw = 0;
    logic [23:0]  bwords [4];
    logic [31:0]  butc, bns;
    logic [15:0]  m_gap = 0, m_mark = 0, m_ovf = 0;
    logic [31:0]  got[$];

    function automatic logic [31:0] mword(logic [159:0] f, int k);
        return f[159-32*k -: 32];
    endfunction

    always @(posedge clk_sys) begin
        bit full;
        if (rst) begin
            mq.delete();
            midx = 0; bw = 0;
            m_gap = 0; m_mark = 0; m_ovf = 0;
        end else begin
            full = (mq.size() == DEPTH);
            if (mq.size() != 0 && fr_rdy) begin
                if (midx == 4) begin
                    midx = 0;
                    void'(mq.pop_front());
                end else midx++;
            end
            if (dp_vld) begin
                if (bw == 0) begin butc = dp_utc; bns = dp_ns; end
                bwords[bw] = dp_data;
                bw++;
                if (bw == 4) begin
                    bw = 0;
                    if (bwords[3] != MARKER) begin
                        if (m_mark != 16'hFFFF) m_mark++;
                    end else if (full) begin
                        if (m_ovf != 16'hFFFF) m_ovf++;
                    end else
                        mq.push_back({butc, bns, 8'h01, bwords[0],
                                      8'h02, bwords[1], 8'h03, bwords[2]});
                end
            end else if (bw != 0) begin
                bw = 0;
                if (m_gap != 16'hFFFF) m_gap++;
            end
        end
    end

    always @(negedge clk_sys) begin
        if (started) begin
            chk("vld", fr_vld, mq.size() != 0);
            chk("level", fr_level, mq.size());
            chk("gap_cnt", err_gap_cnt, m_gap);
            chk("mark_cnt", err_mark_cnt, m_mark);
            chk("ovf_cnt", ovf_cnt, m_ovf);
            if (mq.size() != 0) begin
                chk("data", fr_data, mword(mq[0], midx));
                chk("sof", fr_sof, midx == 0);
                chk("eof", fr_eof, midx == 4);
            end
            if (fr_vld && fr_rdy) got.push_back(fr_data);
        end
    end

    always @(posedge clk_sys) begin
        if (rdy_mode) begin
            #1;
            fr_rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic burst(input logic [31:0] utc, input logic [31:0] ns,
                         input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] c, input logic [23:0] m,
                         input int n);
        logic [23:0] w [4];
        w[0] = a; w[1] = b; w[2] = c; w[3] = m;
        for (int i = 0; i < n; i++) begin
            dp_vld  = 1'b1;
            dp_data = w[i];
            dp_utc  = utc;
            dp_ns   = ns;
            tick();
        end
        dp_vld  = 1'b0;
        dp_data = '0;
        if (n < 4) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_vld"}, fr_vld, 0);
        chk({nm, "_data"}, fr_data, 0);
        chk({nm, "_sof"}, fr_sof, 0);
        chk({nm, "_eof"}, fr_eof, 0);
        chk({nm, "_level"}, fr_level, 0);
    endtask

    initial begin
        rst = 1'b1; dp_vld = 1'b0; dp_data = '0;
        dp_utc = '0; dp_ns = '0; fr_rdy = 1'b0;
        tick();
        started = 1;
        tick();
        rst = 1'b0;
        chk_zero("reset");
        chk("reset_gap", err_gap_cnt, 0);

        // 1) single good burst
        fr_rdy = 1'b1;
        got.delete();
        burst(5, 100, 24'h000111, 24'h000222, 24'h000333, MARKER, 4);
        chk("t1_vld_T+1", fr_vld, 1);
        chk("t1_sof", fr_sof, 1);
        chk("t1_w0", fr_data, 5);
        repeat (6) tick();
        chk("t1_n", got.size(), 5);
        if (got.size() == 5) begin
            chk("t1_w1", got[1], 100);
            chk("t1_w2", got[2], 32'h01000111);
            chk("t1_w3", got[3], 32'h02000222);
            chk("t1_w4", got[4], 32'h03000333);
        end

        // 2) marker error, then gap error
        burst(6, 7, 24'h1, 24'h2, 24'h3, 24'h4445, 4);
        tick();
        chk("t2_mark", err_mark_cnt, 1);
        chk("t2_vld_m", fr_vld, 0);
        burst(6, 7, 24'h1, 24'h2, 24'h3, MARKER, 2);
        chk("t2_gap", err_gap_cnt, 1);
        chk("t2_vld_g", fr_vld, 0);

        // 3) overflow while stalled, then drain in order
        do_reset();
        fr_rdy = 1'b0;
        for (int i = 0; i < 5; i++)
            burst(10 + i, 200 + i, 24'(i), 24'(i + 1), 24'(i + 2), MARKER, 4);
        tick();
        chk("t3_level", fr_level, 4);
        chk("t3_ovf", ovf_cnt, 1);
        got.delete();
        fr_rdy = 1'b1;
        repeat (25) tick();
        chk("t3_n", got.size(), 20);
        if (got.size() == 20) begin
            chk("t3_f0", got[0], 10);
            chk("t3_f3", got[15], 13);
            chk("t3_f3w4", got[19], 32'h03000005);
        end

        // 4) marker on the same edge as a w4 accept
        do_reset();
        fr_rdy = 1'b0;
        for (int i = 0; i < 4; i++)
            burst(30 + i, 0, 24'h10, 24'h20, 24'h30, MARKER, 4);
        fr_rdy = 1'b1;
        tick();
        burst(40, 0, 24'h11, 24'h21, 24'h31, MARKER, 4);
        fr_rdy = 1'b0;
        chk("t4a_ovf", ovf_cnt, 1);
        chk("t4a_level", fr_level, 3);
        fr_rdy = 1'b1;
        tick();
        burst(41, 0, 24'h12, 24'h22, 24'h32, MARKER, 4);
        fr_rdy = 1'b0;
        chk("t4b_ovf", ovf_cnt, 1);
        chk("t4b_level", fr_level, 3);

        // 5) random backpressure over 100 bursts
        do_reset();
        rdy_mode = 1;
        for (int i = 0; i < 100; i++) begin
            int kind = $urandom_range(0, 9);
            burst($urandom, $urandom, 24'($urandom), 24'($urandom),
                  24'($urandom), (kind == 0) ? 24'h4440 : MARKER,
                  (kind == 1) ? 3 : 4);
            repeat ($urandom_range(0, 2)) tick();
        end
        rdy_mode = 0;
        #2;
        fr_rdy = 1'b1;
        for (int i = 0; i < 600 && mq.size() != 0; i++) tick();
        chk("t5_drained", fr_level, 0);

        // 6) reset mid-burst and mid-drain
        do_reset();
        fr_rdy = 1'b0;
        dp_utc = 1; dp_ns = 2;
        dp_vld = 1'b1; dp_data = 24'hA; tick();
        dp_data = 24'hB; tick();
        dp_data = 24'hC; rst = 1'b1; tick();
        rst = 1'b0; dp_vld = 1'b0; dp_data = '0;
        chk_zero("t6a");
        chk("t6a_gap", err_gap_cnt, 0);
        burst(50, 60, 24'h5, 24'h6, 24'h7, MARKER, 4);
        fr_rdy = 1'b1;
        tick();
        tick();
        rst = 1'b1; fr_rdy = 1'b0;
        tick();
        rst = 1'b0;
        chk_zero("t6b");
        got.delete();
        fr_rdy = 1'b1;
        burst(77, 88, 24'hABC, 24'hDEF, 24'h123, MARKER, 4);
        repeat (6) tick();
        chk("t6_n", got.size(), 5);
        if (got.size() == 5) begin
            chk("t6_w0", got[0], 77);
            chk("t6_w1", got[1], 88);
            chk("t6_w4", got[4], 32'h03000123);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
